// File: rtl/comparador_85_serial.sv
// Serial 7485-style magnitude comparator. It compares one SLICE-bit slice per clock,
// starting at the MSB, and stops at the first differing slice. Cascade inputs decide ties.
module comparador_85_serial #(
    parameter int  WIDTH   = 48,
    parameter int  SLICE   = 12,
    localparam int NSLICES = WIDTH / SLICE,
    localparam int CW      = $clog2(NSLICES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ALBi,
    input  logic             AGBi,
    input  logic             AEBi,
    output logic             ocupado,
    output logic             pronto,
    output logic             ALBo,
    output logic             AGBo,
    output logic             AEBo,
    output logic [CW-1:0]    fatias
);

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         casc_q;
    logic [CW-1:0]      idx_q;
    logic [CW-1:0]      fatias_q;
    logic               alb_q, agb_q, aeb_q;
    logic [SLICE-1:0]   sa, sb;
    logic               last_slice;

    always_comb begin
        sa         = a_q[int'(idx_q) * SLICE +: SLICE];
        sb         = b_q[int'(idx_q) * SLICE +: SLICE];
        last_slice = (idx_q == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= INICIAL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL: if (iniciar) state_d = COMPARA;
            COMPARA: if ((sa != sb) || last_slice) state_d = FIM;
            FIM:     state_d = INICIAL;
            default: state_d = INICIAL;
        endcase
    end

    always_comb begin
        ocupado = (state_q == COMPARA);
        pronto  = (state_q == FIM);
    end

    // Operands are captured at the start edge so later input changes cannot disturb the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            idx_q    <= '0;
            fatias_q <= '0;
            alb_q    <= 1'b0;
            agb_q    <= 1'b0;
            aeb_q    <= 1'b0;
        end else begin
            case (state_q)
                INICIAL: begin
                    if (iniciar) begin
                        a_q      <= A;
                        b_q      <= B;
                        casc_q   <= {ALBi, AGBi, AEBi};
                        idx_q    <= CW'(NSLICES - 1);
                        fatias_q <= '0;
                    end
                end
                COMPARA: begin
                    fatias_q <= fatias_q + 1'b1;
                    if (sa < sb) begin
                        {alb_q, agb_q, aeb_q} <= 3'b100;
                    end else if (sa > sb) begin
                        {alb_q, agb_q, aeb_q} <= 3'b010;
                    end else if (last_slice) begin
                        // Ties pass the cascade bits through untouched, even illegal patterns.
                        {alb_q, agb_q, aeb_q} <= casc_q;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALBo   = alb_q;
    assign AGBo   = agb_q;
    assign AEBo   = aeb_q;
    assign fatias = fatias_q;

endmodule
